// File: rtl/wormhole_port_allocator.sv
// Wormhole output-port allocator: round-robin at packet heads, grant locked to the owner until its tail,
// transfers gated by a downstream credit counter. Define ALLOC_WATCHDOG_EN to add a lock watchdog with o_timeout.
module wormhole_port_allocator #(
    parameter int N       = 4,
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           ce,
    input  logic [0:N-1]                   i_request,
    input  logic [0:N-1]                   i_tail,
    input  logic                           i_credit_return,
    output logic [0:N-1]                   o_grant,
    output logic                           o_valid,
    output logic                           o_locked,
    output logic [$clog2(CREDITS+1)-1:0]   o_credits,
    output logic                           o_credit_err
`ifdef ALLOC_WATCHDOG_EN
    ,
    output logic                           o_timeout
`endif
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_owner_nxt;
    logic [0:N-1]    r_prio;
    logic [0:N-1]    w_prio_nxt;
    logic [CW-1:0]   r_credits;
    logic            r_credit_err;

    logic [OW-1:0]   w_prio_idx;
    logic [OW-1:0]   w_win_idx;
    logic            w_win_found;
    logic [OW-1:0]   w_sel_idx;
    logic            w_can_xfer;
    logic [0:N-1]    w_grant;
    logic            w_xfer;
    logic            w_tail_xfer;

    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input int off);
        return OW'((int'(base) + off) % N);
    endfunction

    function automatic logic [0:N-1] to_onehot(input logic [OW-1:0] idx);
        logic [0:N-1] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    always_comb begin
        w_prio_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_prio[i]) w_prio_idx = OW'(i);
        end
    end

    // Descending scan so the last hit is the first requester at or after the priority slot.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_request[wrap_add(w_prio_idx, k)]) begin
                w_win_found = 1'b1;
                w_win_idx   = wrap_add(w_prio_idx, k);
            end
        end
    end

    // Handshake: i_request[i] is valid, o_grant[i] is ready; a flit moves only when both are high.
    assign w_can_xfer  = reset_n && ce && (r_credits != '0);
    assign w_sel_idx   = (r_state == ST_LOCKED) ? r_owner : w_win_idx;
    assign w_xfer      = |w_grant;
    assign w_tail_xfer = w_xfer && i_tail[w_sel_idx];

`ifdef ALLOC_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] r_wd_cnt;
    logic          r_timeout;
    logic          w_wd_fire;

    assign w_wd_fire = (r_state == ST_LOCKED) && !w_xfer && (r_wd_cnt == WW'(TIMEOUT - 1));
    assign o_timeout = r_timeout;
`else
    logic w_wd_unused;
    assign w_wd_unused = (TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_prio  <= to_onehot(OW'(0));
`ifdef ALLOC_WATCHDOG_EN
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ALLOC_WATCHDOG_EN
            r_timeout <= ce && w_wd_fire;
`endif
            if (ce) begin
                r_state <= w_state_nxt;
                r_owner <= w_owner_nxt;
                r_prio  <= w_prio_nxt;
`ifdef ALLOC_WATCHDOG_EN
                if (r_state == ST_IDLE || w_xfer || w_wd_fire) r_wd_cnt <= '0;
                else                                         r_wd_cnt <= r_wd_cnt + WW'(1);
`endif
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_prio_nxt  = r_prio;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (w_tail_xfer) begin
                        w_prio_nxt = to_onehot(wrap_add(w_win_idx, 1));
                    end else begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_win_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_tail_xfer) begin
                    w_state_nxt = ST_IDLE;
                    w_prio_nxt  = to_onehot(wrap_add(r_owner, 1));
                end
`ifdef ALLOC_WATCHDOG_EN
                else if (w_wd_fire) begin
                    w_state_nxt = ST_IDLE;
                    w_prio_nxt  = to_onehot(wrap_add(r_owner, 1));
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_grant = '0;
        if (w_can_xfer) begin
            case (r_state)
                ST_IDLE:   if (w_win_found)          w_grant[w_win_idx] = 1'b1;
                ST_LOCKED: if (i_request[r_owner])   w_grant[r_owner]   = 1'b1;
                default:   w_grant = '0;
            endcase
        end
    end

    // Credits track downstream space independently of ce so no return pulse is ever dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_credits    <= CW'(CREDITS);
            r_credit_err <= 1'b0;
        end else if (w_xfer && !i_credit_return) begin
            r_credits <= r_credits - CW'(1);
        end else if (i_credit_return && !w_xfer) begin
            if (r_credits == CW'(CREDITS)) r_credit_err <= 1'b1;
            else                           r_credits    <= r_credits + CW'(1);
        end
    end

    assign o_grant      = w_grant;
    assign o_valid      = w_xfer;
    assign o_locked     = reset_n && (r_state == ST_LOCKED);
    assign o_credits    = r_credits;
    assign o_credit_err = r_credit_err;

endmodule

// File: tb/tb_wormhole_port_allocator.sv
// Self-checking bench for wormhole_port_allocator: packet-level reference model plus directed literal checks.
module tb_wormhole_port_allocator;

    localparam int N       = 4;
    localparam int CREDITS = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           ce_r = 1'b1;
    logic [0:N-1]   req = '0;
    logic [0:N-1]   tail = '0;
    logic           ret = 1'b0;
    logic [0:N-1]   grant;
    logic           valid;
    logic           locked;
    logic [2:0]     credits;
    logic           credit_err;
`ifdef ALLOC_WATCHDOG_EN
    logic           timeout;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: packet-level view of the allocator
    bit m_ready   = 1'b0;
    bit m_locked  = 1'b0;
    int m_owner   = 0;
    int m_ptr     = 0;
    int m_credits = CREDITS;
    bit m_err     = 1'b0;

    always #5 clk = ~clk;

    wormhole_port_allocator #(.N(N), .CREDITS(CREDITS)) dut (
        .clk            (clk),
        .reset_n        (rstn),
        .ce             (ce_r),
        .i_request      (req),
        .i_tail         (tail),
        .i_credit_return(ret),
        .o_grant        (grant),
        .o_valid        (valid),
        .o_locked       (locked),
        .o_credits      (credits),
        .o_credit_err   (credit_err)
`ifdef ALLOC_WATCHDOG_EN
        ,
        .o_timeout      (timeout)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [0:N-1] model_grant();
        logic [0:N-1] g;
        g = '0;
        if (!rstn || !ce_r || m_credits == 0) return g;
        if (m_locked) begin
            if (req[m_owner]) g[m_owner] = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    g[(m_ptr + k) % N] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    function automatic int first_idx(input logic [0:N-1] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        m_ready <= 1'b1;
        if (!rstn) begin
            m_locked  <= 1'b0;
            m_ptr     <= 0;
            m_credits <= CREDITS;
            m_err     <= 1'b0;
        end else begin
            if ((|model_grant()) && !ret) m_credits <= m_credits - 1;
            else if (ret && !(|model_grant())) begin
                if (m_credits == CREDITS) m_err <= 1'b1;
                else                      m_credits <= m_credits + 1;
            end
            if (|model_grant()) begin
                if (tail[first_idx(model_grant())]) begin
                    m_locked <= 1'b0;
                    m_ptr    <= (first_idx(model_grant()) + 1) % N;
                end else begin
                    m_locked <= 1'b1;
                    m_owner  <= first_idx(model_grant());
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (m_ready) begin
            chk("model grant", grant, model_grant());
            chk("model valid", valid, |model_grant());
            chk("model locked", locked, rstn && m_locked);
            chk("model credits", credits, m_credits);
            chk("model credit_err", credit_err, m_err);
        end
    end

    task automatic cyc(input logic rs, input logic c, input logic [0:N-1] rq,
                       input logic [0:N-1] tl, input logic rt);
        @(negedge clk);
        rstn = rs;
        ce_r = c;
        req  = rq;
        tail = tl;
        ret  = rt;
    endtask

    task automatic expect_o(input string nm, input logic [0:N-1] g, input logic lk, input int cr);
        #2;
        chk({nm, " grant"}, grant, g);
        chk({nm, " locked"}, locked, lk);
        chk({nm, " credits"}, credits, cr);
    endtask

    initial begin
        // Reset with all requesting: outputs gated
        cyc(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0); expect_o("reset", 4'b0000, 1'b0, 4);
        chk("reset credit_err", credit_err, 1'b0);

        // Round-robin of single-flit packets
        cyc(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0); expect_o("rr0", 4'b1000, 1'b0, 4);
        cyc(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1); expect_o("rr1", 4'b0100, 1'b0, 3);
        cyc(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1); expect_o("rr2", 4'b0010, 1'b0, 3);
        cyc(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1); expect_o("rr3", 4'b0001, 1'b0, 3);
        cyc(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1); expect_o("rr4", 4'b1000, 1'b0, 3);
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1); expect_o("rr idle", 4'b0000, 1'b0, 3);

        // Requester 2 sends a 3-flit packet against 0 and 3
        cyc(1'b1, 1'b1, 4'b1011, 4'b1001, 1'b1); expect_o("pkt head", 4'b0010, 1'b0, 4);
        cyc(1'b1, 1'b1, 4'b1011, 4'b1001, 1'b1); expect_o("pkt body", 4'b0010, 1'b1, 4);
        cyc(1'b1, 1'b1, 4'b1011, 4'b1011, 1'b1); expect_o("pkt tail", 4'b0010, 1'b1, 4);
        cyc(1'b1, 1'b1, 4'b1001, 4'b1001, 1'b1); expect_o("pkt next", 4'b0001, 1'b0, 4);

        // Credit exhaustion
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0); expect_o("exh grant", 4'b0100, 1'b0, 4 - i);
        end
        cyc(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0); expect_o("exh stall0", 4'b0000, 1'b0, 0);
        cyc(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0); expect_o("exh stall1", 4'b0000, 1'b0, 0);
        cyc(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b1); expect_o("exh return", 4'b0000, 1'b0, 0);
        cyc(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0); expect_o("exh one more", 4'b0100, 1'b0, 1);
        cyc(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0); expect_o("exh stall2", 4'b0000, 1'b0, 0);

        // Simultaneous transfer and return, then overflow
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1); expect_o("ret a", 4'b0000, 1'b0, 0);
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1); expect_o("ret b", 4'b0000, 1'b0, 1);
        cyc(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1); expect_o("both", 4'b0001, 1'b0, 2);
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1); expect_o("both after", 4'b0000, 1'b0, 2);
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1); expect_o("ret c", 4'b0000, 1'b0, 3);
        chk("pre-overflow credit_err", credit_err, 1'b0);
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1); expect_o("overflow", 4'b0000, 1'b0, 4);
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0); expect_o("sat", 4'b0000, 1'b0, 4);
        chk("credit_err set", credit_err, 1'b1);
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0); expect_o("sat hold", 4'b0000, 1'b0, 4);
        chk("credit_err sticky", credit_err, 1'b1);

        // ce low mid-packet with credit returns
        cyc(1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0); expect_o("ce pre0", 4'b0010, 1'b0, 4);
        cyc(1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0); expect_o("ce pre1", 4'b0010, 1'b0, 3);
        cyc(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0); expect_o("ce head", 4'b0001, 1'b0, 2);
        cyc(1'b1, 1'b0, 4'b1001, 4'b0000, 1'b1); expect_o("ce off0", 4'b0000, 1'b1, 1);
        cyc(1'b1, 1'b0, 4'b1001, 4'b0000, 1'b1); expect_o("ce off1", 4'b0000, 1'b1, 2);
        cyc(1'b1, 1'b0, 4'b1001, 4'b0000, 1'b1); expect_o("ce off2", 4'b0000, 1'b1, 3);
        cyc(1'b1, 1'b1, 4'b1001, 4'b0001, 1'b0); expect_o("ce resume", 4'b0001, 1'b1, 4);
        cyc(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0); expect_o("ce after", 4'b1000, 1'b0, 3);

        // Reset mid-packet drops the lock
        cyc(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0); expect_o("rst head", 4'b0100, 1'b0, 2);
        cyc(1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0); expect_o("rst mid", 4'b0000, 1'b0, 1);
        cyc(1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0); expect_o("rst after", 4'b0010, 1'b0, 4);
        chk("rst credit_err", credit_err, 1'b0);
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0); expect_o("final", 4'b0000, 1'b0, 3);

        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wormhole_port_allocator.md
Name: wormhole_port_allocator

Overview:
- Output-port allocator for one router output port. It shares the port among N input-port requesters at packet granularity (wormhole).
- Round-robin arbitration picks a winner at each packet head. The grant is then locked to that winner until its tail flit transfers.
- Transfers are gated by a downstream credit counter (credit-based flow control).
- Sits between the input-port VC buffers and the output crossbar column. o_grant drives the crossbar select.

Parameters:
- N, 4, number of requesters (input ports), >=2.
- CREDITS, 4, downstream buffer depth in flits; credit counter reset value, >=1.
- CW, $clog2(CREDITS+1), credit counter width (derived, not overridden).
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset; synchronous, active-low.
- ce  input  1  clock enable; low = freeze arbitration and lock state.
- i_request  input  [0:N-1]  requester i presents a valid flit this cycle.
- i_tail  input  [0:N-1]  flit presented by requester i is a tail (head+tail = single-flit packet).
- i_credit_return  input  1  one-cycle pulse; downstream freed one slot.
- o_grant  output  [0:N-1]  one-hot (or zero) grant; the flit of the granted requester transfers this cycle.
- o_valid  output  1  = |o_grant; flit written to output this cycle.
- o_locked  output  1  allocator is mid-packet (LOCKED state).
- o_credits  output  CW  current credit count.
- o_credit_err  output  1  sticky; credit overflow detected.

Behaviour:
- Registered state: fsm (IDLE/LOCKED), owner index, one-hot priority vector, credit counter, credit_err.
- Reset (reset_n low at clk edge) sets:
  - fsm=IDLE, priority=requester 0, credits=CREDITS, credit_err=0.
  - While reset_n is low, o_grant=0, o_valid=0, o_locked=0.
- Grant is combinational from registered state and current inputs (0-cycle latency). State updates on the clk edge where the transfer happens.
- Transfer allowed only when ce=1 and credits>0. Otherwise o_grant=0.
- IDLE:
  - Winner = first requester at or after the priority position, searching cyclically (wraps N-1 -> 0).
  - o_grant = one-hot winner.
  - If the winner's i_tail=1 (single-flit packet): stay IDLE; priority <= one-hot (winner+1) mod N.
  - Else: fsm <= LOCKED; owner <= winner; priority unchanged.
  - No request: o_grant=0, state unchanged.
- LOCKED:
  - o_grant = one-hot owner iff i_request[owner]. Requests from all others are ignored (o_grant bit 0).
  - Owner flit with i_tail=1 transfers: fsm <= IDLE; priority <= (owner+1) mod N.
  - Owner bubble (i_request[owner]=0): hold LOCKED, no grant.
- Credits:
  - -1 on each transfer, +1 on i_credit_return.
  - Both in the same cycle: unchanged.
  - Credit counting ignores ce; returns are never lost.
  - Return when credits==CREDITS and no transfer that cycle: counter saturates at CREDITS; credit_err <= 1 (sticky until reset).
  - credits==0: no transfer; lock is held.
- ce=0: o_grant=0; fsm/owner/priority held.
- Reset mid-packet: the lock is dropped immediately. Upstream is responsible for discarding partial packets.
- o_locked = (fsm==LOCKED).

Optional Feature:
- Macro ALLOC_WATCHDOG_EN.
- Defined:
  - Adds a cycle counter in LOCKED, cleared on every owner transfer and on entry to LOCKED.
  - If it reaches TIMEOUT: fsm <= IDLE; priority <= owner+1; one-cycle pulse on extra output o_timeout (1 bit, reset 0).
- Undefined:
  - No counter, no o_timeout port.
  - The lock holds indefinitely until the tail flit.

Test Plan:
- Reset, N=4, CREDITS=4, i_request=1111, all i_tail=1 each cycle, i_credit_return pulsed every cycle from cycle 2 -> grants 1000, 0100, 0010, 0001, 1000; credits never reach 0; o_locked stays 0.
- Requester 2 sends a 3-flit packet (tail on 3rd flit) while requesters 0 and 3 request continuously:
  - o_grant=0010 for 3 transfers; o_locked=1 after the head.
  - Next grant goes to requester 3.
- Credit exhaustion: no credit returns, single requester sends 6 single-flit packets -> 4 grants, then o_grant=0 with credits=0. One i_credit_return -> exactly one more grant.
- Transfer and i_credit_return in the same cycle at credits=2 -> credits stays 2. Extra return at credits=4 with no transfer -> credits=4, o_credit_err=1 and stays 1.
- ce=0 for 3 cycles mid-packet with credit returns -> o_grant=0, o_locked=1, credits incremented; after ce=1 the same owner resumes.
- With ALLOC_WATCHDOG_EN and TIMEOUT=8: owner stalls after the head -> o_timeout pulses 8 cycles after the last owner transfer; the next grant goes to owner+1.
